multiplier_datapath: RTL

//  Datapath stage of the sequential 8x8 unsigned multiplier. It sits directly downstream of multiplier_controller and is driven by it.
//  Per step it forms one 4x4 nibble partial product, shifts it by 0/4/8 bits and accumulates it into a 16-bit sum.
//  It returns the step counter to the controller and latches the final product when the controller raises done.

---
 rtl/multiplier_pkg.sv | 36 +++
 rtl/mult4x4.sv | 13 +
 rtl/multiplier_datapath.sv | 80 ++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared encodings and widths for the sequential 8x8 multiplier
// (controller and datapath both import this package).
package multiplier_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  // Which operand nibbles feed the 4x4 multiplier: a-nibble first, b-nibble second.
  typedef enum logic [1:0] {
    SEL_LL = 2'b00,
    SEL_LH = 2'b01,
    SEL_HL = 2'b10,
    SEL_HH = 2'b11
  } input_sel_e;

  // Left shift applied to the partial product; 2'b11 is reserved and aligns like SH0.
  typedef enum logic [1:0] {
    SH0 = 2'b00,
    SH4 = 2'b01,
    SH8 = 2'b10
  } shift_sel_e;

  // Zero-extend an 8-bit partial product to the accumulator width and align it.
  function automatic logic [PROD_W-1:0] align_pp(input logic [2*NIB_W-1:0] pp,
                                                 input logic [1:0]         sel);
    logic [PROD_W-1:0] ext;
    ext = PROD_W'(pp);
    case (sel)
      SH4:     return ext << 4;
      SH8:     return ext << 8;
      default: return ext;
    endcase
  endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier producing a full 8-bit product.
module mult4x4
  import multiplier_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  // Operands widened first so the product keeps all 8 bits.
  assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};

endmodule

// File: rtl/multiplier_datapath.sv
// Datapath of the sequential 8x8 multiplier: one nibble partial product per
// step, aligned and accumulated into a 16-bit sum; final sum latched on done.
module multiplier_datapath
  import multiplier_pkg::*;
(
  input  logic              clk,
  input  logic              reset_a,
  input  logic [OP_W-1:0]   dataa,
  input  logic [OP_W-1:0]   datab,
  input  logic [1:0]        input_sel,
  input  logic [1:0]        shift_sel,
  input  logic              clk_ena,
  input  logic              sclr_n,
  input  logic              done,
  output logic [1:0]        count,
  output logic [PROD_W-1:0] acc,
  output logic [PROD_W-1:0] product,
  output logic              product_valid
);

  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [2*NIB_W-1:0] pp;
  logic [PROD_W-1:0]  shifted;

  // Pick the nibble pair for this step; every select code maps to a defined pair.
  always_comb begin
    nib_a = op_a[NIB_W-1:0];
    nib_b = op_b[NIB_W-1:0];
    case (input_sel)
      SEL_LH: nib_b = op_b[OP_W-1:NIB_W];
      SEL_HL: nib_a = op_a[OP_W-1:NIB_W];
      SEL_HH: begin
        nib_a = op_a[OP_W-1:NIB_W];
        nib_b = op_b[OP_W-1:NIB_W];
      end
      default: ;
    endcase
  end

  mult4x4 u_mult4x4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  assign shifted = align_pp(pp, shift_sel);

  // Operand capture on clear, accumulate and count on enabled steps, else hold.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (!sclr_n) begin
      op_a  <= dataa;
      op_b  <= datab;
      acc   <= '0;
      count <= '0;
    end else if (clk_ena) begin
      acc   <= acc + shifted;
      count <= count + 2'd1;
    end
  end

  // Latch the pre-update accumulator on done and flag it for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      if (done) product <= acc;
      product_valid <= done;
    end
  end

endmodule
